// File: rtl/layer_sequencer.sv
// Layer loop-nest sequencer: walks row/col/channel indices for one job,
// issues PE-array beats over valid/ready, drains the PE pipe, reports done.
module layer_sequencer #(
    parameter int ROW_W     = 8,
    parameter int COL_W     = 8,
    parameter int CH_W      = 6,
    parameter int DRAIN_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [ROW_W-1:0] cfg_rows,
    input  logic [COL_W-1:0] cfg_cols,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic             issue_ready,
    output logic             issue_valid,
    output logic [ROW_W-1:0] row_idx,
    output logic [COL_W-1:0] col_idx,
    output logic [CH_W-1:0]  ch_idx,
    output logic             issue_last,
    output logic             busy,
    output logic             done,
    output logic             aborted
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [ROW_W-1:0] r_rows;
    logic [COL_W-1:0] r_cols;
    logic [CH_W-1:0]  r_ch;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [CH_W-1:0]  r_chi;
    logic [DW-1:0]    r_drain;
    logic             r_aborted;

    logic w_run;
    logic w_drain;
    logic w_accept;
    logic w_abort;
    logic w_fire;
    logic w_cfg_zero;
    logic w_ch_wrap;
    logic w_col_wrap;
    logic w_row_wrap;
    logic w_last;

    assign w_run      = (r_state == S_RUN);
    assign w_drain    = (r_state == S_DRAIN);
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_abort    = abort && (w_run || w_drain);
    assign w_fire     = w_run && issue_ready && !abort;
    assign w_cfg_zero = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_ch == '0);
    assign w_ch_wrap  = (r_chi == r_ch - CH_W'(1));
    assign w_col_wrap = (r_col == r_cols - COL_W'(1));
    assign w_row_wrap = (r_row == r_rows - ROW_W'(1));
    assign w_last     = w_ch_wrap && w_col_wrap && w_row_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = w_cfg_zero ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (abort)
                    w_next = S_IDLE;
                else if (issue_ready && w_last)
                    w_next = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                     w_next = S_IDLE;
                else if (r_drain <= DW'(1))    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Indices walk ch fastest, then col, then row; cleared after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows    <= '0;
            r_cols    <= '0;
            r_ch      <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_chi     <= '0;
            r_drain   <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort;
            if (w_accept) begin
                r_rows <= cfg_rows;
                r_cols <= cfg_cols;
                r_ch   <= cfg_ch;
                r_row  <= '0;
                r_col  <= '0;
                r_chi  <= '0;
            end else if (w_abort || (r_state == S_DONE) || (w_fire && w_last)) begin
                r_row <= '0;
                r_col <= '0;
                r_chi <= '0;
            end else if (w_fire) begin
                if (!w_ch_wrap) begin
                    r_chi <= r_chi + CH_W'(1);
                end else begin
                    r_chi <= '0;
                    if (!w_col_wrap) begin
                        r_col <= r_col + COL_W'(1);
                    end else begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end
                end
            end
            if (w_fire && w_last)
                r_drain <= DW'(DRAIN_CYC);
            else if (w_drain && (r_drain != '0))
                r_drain <= r_drain - DW'(1);
        end
    end

    assign issue_valid = w_run;
    assign issue_last  = w_run && w_last;
    assign row_idx     = r_row;
    assign col_idx     = r_col;
    assign ch_idx      = r_chi;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign aborted     = r_aborted;
endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed and randomized jobs checked against
// a beat-count / timeline model of the sequencer.
module tb_layer_sequencer;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_rows = '0;
    logic [7:0] cfg_cols = '0;
    logic [5:0] cfg_ch = '0;
    logic       issue_ready = 1'b0;
    logic       issue_valid;
    logic [7:0] row_idx;
    logic [7:0] col_idx;
    logic [5:0] ch_idx;
    logic       issue_last;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [4:0] flags;
    logic [21:0] idx;

    int n_vec = 0;
    int n_err = 0;

    layer_sequencer #(
        .ROW_W(8), .COL_W(8), .CH_W(6), .DRAIN_CYC(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_ch(cfg_ch),
        .issue_ready(issue_ready), .issue_valid(issue_valid),
        .row_idx(row_idx), .col_idx(col_idx), .ch_idx(ch_idx),
        .issue_last(issue_last), .busy(busy), .done(done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    assign flags = {issue_valid, issue_last, busy, done, aborted};
    assign idx   = {row_idx, col_idx, ch_idx};

    // Beat k of a rows x cols x ch job, channel fastest.
    function automatic logic [21:0] beat_idx(int k, int c, int h);
        int r;
        int cc;
        int hh;
        r  = k / (c * h);
        cc = (k / h) % c;
        hh = k % h;
        return {8'(r), 8'(cc), 6'(hh)};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({flags, idx} !== '0) begin
            n_err++;
            $display("FAIL reset_hold got=%b/%h exp=0", flags, idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({flags, idx} !== '0) begin
            n_err++;
            $display("FAIL reset_release got=%b/%h exp=0", flags, idx);
        end
    endtask

    task automatic test_basic();
        logic [4:0] exp;
        cfg_rows = 2; cfg_cols = 2; cfg_ch = 2;
        issue_ready = 1'b1;
        start = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            start = 1'b0;
            exp = {t <= 8, t == 8, (t >= 1) && (t <= 13), t == 13, 1'b0};
            n_vec++;
            if (flags !== exp) begin
                n_err++;
                $display("FAIL basic_flags t=%0d got=%b exp=%b", t, flags, exp);
            end
            if (t <= 8) begin
                n_vec++;
                if (idx !== beat_idx(t - 1, 2, 2)) begin
                    n_err++;
                    $display("FAIL basic_idx t=%0d got=%h exp=%h",
                             t, idx, beat_idx(t - 1, 2, 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int j = 0; j < 8; j++) begin
            int r;
            int c;
            int h;
            int tot;
            int k;
            int guard;
            logic rdy;
            r = (j == 0) ? 2 : int'($urandom_range(1, 3));
            c = (j == 0) ? 2 : int'($urandom_range(1, 3));
            h = (j == 0) ? 2 : int'($urandom_range(1, 4));
            tot = r * c * h;
            cfg_rows = 8'(r); cfg_cols = 8'(c); cfg_ch = 6'(h);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            k = 0;
            guard = 0;
            while (k < tot && guard < 500) begin
                n_vec++;
                if (flags !== {1'b1, k == tot - 1, 3'b100}) begin
                    n_err++;
                    $display("FAIL bp_flags job=%0d k=%0d got=%b exp=%b",
                             j, k, flags, {1'b1, k == tot - 1, 3'b100});
                end
                n_vec++;
                if (idx !== beat_idx(k, c, h)) begin
                    n_err++;
                    $display("FAIL bp_idx job=%0d k=%0d got=%h exp=%h",
                             j, k, idx, beat_idx(k, c, h));
                end
                rdy = (j == 0) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
                issue_ready = rdy;
                start = 1'($urandom_range(0, 1));
                cfg_rows = 8'($urandom); cfg_cols = 8'($urandom);
                cfg_ch = 6'($urandom);
                if (rdy) k++;
                guard++;
                @(negedge clk);
            end
            start = 1'b0;
            n_vec++;
            if (k != tot) begin
                n_err++;
                $display("FAIL bp_timeout job=%0d got=%0d beats exp=%0d", j, k, tot);
            end
            for (int d = 0; d < D; d++) begin
                n_vec++;
                if (flags !== 5'b00100) begin
                    n_err++;
                    $display("FAIL bp_drain job=%0d d=%0d got=%b exp=00100", j, d, flags);
                end
                issue_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            n_vec++;
            if (flags !== 5'b00110) begin
                n_err++;
                $display("FAIL bp_done job=%0d got=%b exp=00110", j, flags);
            end
            start = 1'b1;
            @(negedge clk);
            n_vec++;
            if ({flags, idx} !== '0) begin
                n_err++;
                $display("FAIL bp_idle job=%0d got=%b/%h exp=0", j, flags, idx);
            end
            start = 1'b0;
            issue_ready = 1'b1;
        end
    endtask

    task automatic test_zero_cfg();
        for (int z = 0; z < 3; z++) begin
            cfg_rows = (z == 0) ? 8'd0 : 8'd3;
            cfg_cols = (z == 1) ? 8'd0 : 8'd2;
            cfg_ch   = (z == 2) ? 6'd0 : 6'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_vec++;
            if (flags !== 5'b00110) begin
                n_err++;
                $display("FAIL zero_done z=%0d got=%b exp=00110", z, flags);
            end
            @(negedge clk);
            n_vec++;
            if (flags !== 5'b00000) begin
                n_err++;
                $display("FAIL zero_idle z=%0d got=%b exp=00000", z, flags);
            end
        end
    endtask

    task automatic test_abort();
        int hs;
        int dn;
        int t;
        cfg_rows = 3; cfg_cols = 3; cfg_ch = 1;
        issue_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (idx !== beat_idx(k, 3, 1) || flags !== 5'b10100) begin
                n_err++;
                $display("FAIL abort_run k=%0d got=%b/%h exp=10100/%h",
                         k, flags, idx, beat_idx(k, 3, 1));
            end
            if (k == 3) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        n_vec++;
        if ({flags, idx} !== {5'b00001, 22'd0}) begin
            n_err++;
            $display("FAIL abort_pulse got=%b/%h exp=00001/0", flags, idx);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++;
        if (flags !== 5'b00000) begin
            n_err++;
            $display("FAIL abort_idle_ignored got=%b exp=00000", flags);
        end
        cfg_rows = 2; cfg_cols = 1; cfg_ch = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if ({flags, idx} !== {5'b10100, 22'd0}) begin
            n_err++;
            $display("FAIL abort_restart got=%b/%h exp=10100/0", flags, idx);
        end
        hs = 0; dn = 0; t = 0;
        while (busy && t < 50) begin
            hs += int'(issue_valid && issue_ready);
            dn += int'(done);
            t++;
            @(negedge clk);
        end
        n_vec++;
        if (hs != 2 || dn != 1) begin
            n_err++;
            $display("FAIL abort_restart_job got=%0d beats %0d done exp=2 beats 1 done", hs, dn);
        end
        // abort during DRAIN: job 1x1x2 -> RUN 1..2, DRAIN 3..6
        cfg_rows = 1; cfg_cols = 1; cfg_ch = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++;
        if (flags !== 5'b00001) begin
            n_err++;
            $display("FAIL abort_drain_pulse got=%b exp=00001", flags);
        end
        dn = 0;
        for (int i = 0; i < D + 2; i++) begin
            @(negedge clk);
            dn += int'(done || busy || aborted);
        end
        n_vec++;
        if (dn != 0) begin
            n_err++;
            $display("FAIL abort_drain_quiet got=%0d active cycles exp=0", dn);
        end
    endtask

    task automatic test_start_ignored();
        int hs;
        int donet;
        cfg_rows = 2; cfg_cols = 2; cfg_ch = 2;
        issue_ready = 1'b1;
        start = 1'b1;
        hs = 0; donet = -1;
        for (int t = 1; t <= 15; t++) begin
            @(negedge clk);
            start = (t == 3);
            if (t == 3) begin
                cfg_rows = 5; cfg_cols = 5; cfg_ch = 5;
            end
            if (issue_valid) begin
                n_vec++;
                if (idx !== beat_idx(hs, 2, 2)) begin
                    n_err++;
                    $display("FAIL restart_idx t=%0d got=%h exp=%h",
                             t, idx, beat_idx(hs, 2, 2));
                end
                hs++;
            end
            if (done && donet < 0) donet = t;
        end
        n_vec++;
        if (hs != 8 || donet != 13) begin
            n_err++;
            $display("FAIL restart_job got=%0d beats done@%0d exp=8 beats done@13", hs, donet);
        end
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 2; p++) begin
            int r;
            int c;
            int h;
            int tot;
            int hs;
            int donet;
            cfg_rows = 1; cfg_cols = 2; cfg_ch = 2;
            issue_ready = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat ((p == 0) ? 5 : 2) @(negedge clk);
            n_vec++;
            if (busy !== 1'b1 || issue_valid !== (p == 1)) begin
                n_err++;
                $display("FAIL rst_pre p=%0d got=%b exp busy=1 valid=%0d", p, flags, p);
            end
            rst_n = 1'b0;
            #1;
            n_vec++;
            if ({flags, idx} !== '0) begin
                n_err++;
                $display("FAIL rst_async p=%0d got=%b/%h exp=0", p, flags, idx);
            end
            @(negedge clk);
            rst_n = 1'b1;
            r = int'($urandom_range(1, 2));
            c = int'($urandom_range(1, 3));
            h = int'($urandom_range(1, 3));
            tot = r * c * h;
            cfg_rows = 8'(r); cfg_cols = 8'(c); cfg_ch = 6'(h);
            start = 1'b1;
            hs = 0; donet = -1;
            for (int t = 1; t <= tot + D + 3; t++) begin
                @(negedge clk);
                start = 1'b0;
                hs += int'(issue_valid);
                if (done && donet < 0) donet = t;
            end
            n_vec++;
            if (hs != tot || donet != tot + D + 1) begin
                n_err++;
                $display("FAIL rst_rerun p=%0d got=%0d beats done@%0d exp=%0d beats done@%0d",
                         p, hs, donet, tot, tot + D + 1);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_cfg();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
